// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave responder
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_MODE   = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,    // minimum 2
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchronizer and keep one extra copy for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 slave with parallel load/read handshake
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              load_slave,
    input  logic [DATA_W-1:0] data_in_slave,
    input  logic              read_slave,
    output logic [DATA_W-1:0] data_out_slave,
    output logic              rx_valid,
    output logic              overrun,
    output logic              busy,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso
);

    localparam int               CNT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             SCLK_IDLE = (SPI_MODE >= 2);

    spi_slv_state_e r_state;
    spi_slv_state_e w_next_state;

    logic [DATA_W-1:0]      r_tx_hold;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_rx_hold;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_rx_valid;
    logic                   r_overrun;
    logic                   r_reload;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_flush;
    logic                   r_ss_armed;

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_ss_s, w_ss_rise, w_ss_fall;
    logic w_mosi_s;
    logic w_start;
    logic [DATA_W-1:0] w_rx_word;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk (mclk),
        .i_rst (reset),
        .i_d   (sclk),
        .o_sync(w_sclk_s),
        .o_rise(w_sclk_rise),
        .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .i_clk (mclk),
        .i_rst (reset),
        .i_d   (ss_n),
        .o_sync(w_ss_s),
        .o_rise(w_ss_rise),
        .o_fall(w_ss_fall)
    );

    // mosi uses the same depth as sclk so a sampled bit lines up with its sclk rise
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_rx_word = {r_rx_shift[DATA_W-2:0], w_mosi_s};

    // Arm frame start only after ss_n has been seen high on a fully flushed synchronizer,
    // so a select held low across reset cannot start a frame
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_flush    <= '0;
            r_ss_armed <= 1'b0;
        end else begin
            r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            r_ss_armed <= r_ss_armed | (r_flush[SYNC_STAGES-1] & w_ss_s);
        end
    end

    // A frame only starts with sclk resting at its idle level
    assign w_start = (r_state == IDLE) && w_ss_fall && r_ss_armed && (w_sclk_s == SCLK_IDLE);

    // State register
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_next_state = ACTIVE;
            ACTIVE:  if (w_ss_rise) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Serial outputs: miso is only driven while selected
    always_comb begin
        busy = 1'b0;
        miso = 1'b0;
        if (r_state == ACTIVE) begin
            busy = 1'b1;
            miso = r_tx_shift[DATA_W-1];
        end
    end

    // Shift registers, word completion and the parallel handshake
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_tx_hold  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_hold  <= '0;
            r_bit_cnt  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_reload   <= 1'b0;
        end else begin
            if (load_slave) r_tx_hold  <= data_in_slave;
            if (read_slave) r_rx_valid <= 1'b0;

            if (w_start) begin
                r_tx_shift <= r_tx_hold;
                r_bit_cnt  <= '0;
                r_reload   <= 1'b0;
            end else if (r_state == ACTIVE) begin
                if (w_ss_rise) begin
                    // partial word is dropped; rx_hold keeps the last full word
                    r_bit_cnt <= '0;
                    r_reload  <= 1'b0;
                end else begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_word;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_rx_hold  <= w_rx_word;
                            r_rx_valid <= 1'b1;
                            if (r_rx_valid && !read_slave) r_overrun <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_reload   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_sclk_fall) begin
                        // after the last bit, the next word comes from tx_hold instead of a shift
                        if (r_reload) begin
                            r_tx_shift <= r_tx_hold;
                            r_reload   <= 1'b0;
                        end else begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    assign data_out_slave = r_rx_hold;
    assign rx_valid       = r_rx_valid;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - self-checking bench for spi_slave_responder
module tb_spi_slave_responder;

    logic       mclk = 1'b0;
    logic       reset = 1'b0;
    logic       load_slave = 1'b0;
    logic [7:0] data_in_slave = 8'h00;
    logic       read_slave = 1'b0;
    logic [7:0] data_out_slave;
    logic       rx_valid;
    logic       overrun;
    logic       busy;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;

    int n_checks = 0;
    int n_errors = 0;

    // reference model of the slave's parallel-side state
    logic [7:0] m_tx_hold;
    logic [7:0] m_rx_hold;
    logic       m_rx_valid;
    logic       m_overrun;

    spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .mclk          (mclk),
        .reset         (reset),
        .load_slave    (load_slave),
        .data_in_slave (data_in_slave),
        .read_slave    (read_slave),
        .data_out_slave(data_out_slave),
        .rx_valid      (rx_valid),
        .overrun       (overrun),
        .busy          (busy),
        .sclk          (sclk),
        .ss_n          (ss_n),
        .mosi          (mosi),
        .miso          (miso)
    );

    always #5 mclk = ~mclk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic model_clear();
        m_tx_hold  = 8'h00;
        m_rx_hold  = 8'h00;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge mclk);
        reset = 1'b1;
        ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        load_slave = 1'b0; read_slave = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        model_clear();
        wait_cycles(6);
    endtask

    task automatic load(input logic [7:0] v);
        load_slave = 1'b1;
        data_in_slave = v;
        @(negedge mclk);
        load_slave = 1'b0;
        m_tx_hold = v;
    endtask

    task automatic read_pulse();
        read_slave = 1'b1;
        @(negedge mclk);
        read_slave = 1'b0;
        m_rx_valid = 1'b0;
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
    endtask

    task automatic ss_end();
        wait_cycles(4);
        ss_n = 1'b1;
        wait_cycles(8);
    endtask

    // Master side of one word, sclk = mclk/8; optional load mid-word and read before the first rise
    task automatic xfer_word(input logic [7:0] tx, input int nbits, input bit do_load,
                             input logic [7:0] load_val, input bit do_read, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            if (do_read && i == 7) begin
                read_slave = 1'b1;
                @(negedge mclk);
                read_slave = 1'b0;
                m_rx_valid = 1'b0;
                wait_cycles(3);
            end else begin
                wait_cycles(4);
            end
            rx[i] = miso;
            sclk = 1'b1;
            if (do_load && i == 4) begin
                load_slave = 1'b1;
                data_in_slave = load_val;
                @(negedge mclk);
                load_slave = 1'b0;
                m_tx_hold = load_val;
                wait_cycles(3);
            end else begin
                wait_cycles(4);
            end
            sclk = 1'b0;
        end
        if (nbits == 8) begin
            if (m_rx_valid) m_overrun = 1'b1;
            m_rx_hold  = tx;
            m_rx_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({data_out_slave, rx_valid, overrun, busy, miso} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected %h", {data_out_slave, rx_valid, overrun, busy, miso}, 12'h000);
        end
        wait_cycles(3);
        reset = 1'b0;
        model_clear();
        wait_cycles(6);
        n_checks++;
        if ({busy, miso} !== 2'b00) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %b expected %b", {busy, miso}, 2'b00);
        end
    endtask

    task automatic test_basic_word();
        logic [7:0] rx;
        load(8'hA5);
        ss_begin();
        xfer_word(8'h3C, 8, 1'b0, 8'h00, 1'b0, rx);
        ss_end();
        n_checks++;
        if (rx !== 8'hA5) begin n_errors++; $display("FAIL basic_miso: got %h expected %h", rx, 8'hA5); end
        n_checks++;
        if (data_out_slave !== 8'h3C) begin n_errors++; $display("FAIL basic_data_out: got %h expected %h", data_out_slave, 8'h3C); end
        n_checks++;
        if ({rx_valid, overrun} !== 2'b10) begin n_errors++; $display("FAIL basic_flags: got %b expected %b", {rx_valid, overrun}, 2'b10); end
        n_checks++;
        if ({busy, miso} !== 2'b00) begin n_errors++; $display("FAIL basic_idle: got %b expected %b", {busy, miso}, 2'b00); end
    endtask

    task automatic test_handshake();
        read_slave = 1'b1;
        @(negedge mclk);
        read_slave = 1'b0;
        m_rx_valid = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL handshake_valid: got %b expected %b", rx_valid, 1'b0); end
        n_checks++;
        if (data_out_slave !== 8'h3C) begin n_errors++; $display("FAIL handshake_data: got %h expected %h", data_out_slave, 8'h3C); end
        read_pulse();
        n_checks++;
        if ({rx_valid, overrun} !== 2'b00) begin n_errors++; $display("FAIL handshake_idle_read: got %b expected %b", {rx_valid, overrun}, 2'b00); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx0, rx1;
        load(8'h11);
        ss_begin();
        xfer_word(8'h01, 8, 1'b1, 8'h22, 1'b0, rx0);
        xfer_word(8'h02, 8, 1'b0, 8'h00, 1'b1, rx1);
        ss_end();
        n_checks++;
        if (rx0 !== 8'h11) begin n_errors++; $display("FAIL b2b_miso0: got %h expected %h", rx0, 8'h11); end
        n_checks++;
        if (rx1 !== 8'h22) begin n_errors++; $display("FAIL b2b_miso1: got %h expected %h", rx1, 8'h22); end
        n_checks++;
        if (data_out_slave !== 8'h02) begin n_errors++; $display("FAIL b2b_data_out: got %h expected %h", data_out_slave, 8'h02); end
        n_checks++;
        if ({rx_valid, overrun} !== 2'b10) begin n_errors++; $display("FAIL b2b_flags: got %b expected %b", {rx_valid, overrun}, 2'b10); end
    endtask

    task automatic test_overrun();
        logic [7:0] rx0, rx1;
        read_pulse();
        ss_begin();
        xfer_word(8'hF0, 8, 1'b0, 8'h00, 1'b0, rx0);
        xfer_word(8'h0F, 8, 1'b0, 8'h00, 1'b0, rx1);
        ss_end();
        n_checks++;
        if (data_out_slave !== 8'h0F) begin n_errors++; $display("FAIL ovr_data_out: got %h expected %h", data_out_slave, 8'h0F); end
        n_checks++;
        if ({rx_valid, overrun} !== 2'b11) begin n_errors++; $display("FAIL ovr_flags: got %b expected %b", {rx_valid, overrun}, 2'b11); end
        n_checks++;
        if ({rx0, rx1} !== {m_tx_hold, m_tx_hold}) begin n_errors++; $display("FAIL ovr_miso: got %h expected %h", {rx0, rx1}, {m_tx_hold, m_tx_hold}); end
    endtask

    task automatic test_abort();
        logic [7:0] rx, tx_v;
        apply_reset();
        load(8'h5A);
        ss_begin();
        xfer_word(8'h3C, 8, 1'b0, 8'h00, 1'b0, rx);
        ss_end();
        tx_v = 8'hC3;
        load(tx_v);
        ss_begin();
        xfer_word(8'hFF, 5, 1'b0, 8'h00, 1'b0, rx);
        ss_end();
        n_checks++;
        if (rx[7:3] !== tx_v[7:3]) begin n_errors++; $display("FAIL abort_partial_miso: got %h expected %h", rx[7:3], tx_v[7:3]); end
        n_checks++;
        if ({data_out_slave, rx_valid, overrun} !== {8'h3C, 2'b10}) begin
            n_errors++;
            $display("FAIL abort_hold: got %h expected %h", {data_out_slave, rx_valid, overrun}, {8'h3C, 2'b10});
        end
        ss_begin();
        xfer_word(8'h81, 8, 1'b0, 8'h00, 1'b0, rx);
        ss_end();
        n_checks++;
        if (rx !== tx_v) begin n_errors++; $display("FAIL abort_next_miso: got %h expected %h", rx, tx_v); end
        n_checks++;
        if ({data_out_slave, rx_valid, overrun} !== {m_rx_hold, m_rx_valid, m_overrun}) begin
            n_errors++;
            $display("FAIL abort_next_rx: got %h expected %h", {data_out_slave, rx_valid, overrun}, {m_rx_hold, m_rx_valid, m_overrun});
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] rx, tx_v, mo_v;
        int seen, lat;
        load(8'h96);
        ss_begin();
        xfer_word(8'hA7, 8, 1'b0, 8'h00, 1'b0, rx);
        xfer_word(8'hFF, 3, 1'b0, 8'h00, 1'b0, rx);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({data_out_slave, rx_valid, overrun, busy, miso} !== 12'h000) begin
            n_errors++;
            $display("FAIL async_reset_outputs: got %h expected %h", {data_out_slave, rx_valid, overrun, busy, miso}, 12'h000);
        end
        @(negedge mclk);
        wait_cycles(2);
        reset = 1'b0;
        model_clear();
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge mclk);
            if (k % 4 == 0) sclk = ~sclk;
            if (busy || miso) seen++;
        end
        sclk = 1'b0;
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL held_ss_no_entry: got %0d active cycles expected %0d", seen, 0); end
        ss_n = 1'b1;
        wait_cycles(8);
        tx_v = 8'($urandom);
        mo_v = 8'($urandom);
        load(tx_v);
        ss_begin();
        lat = 0;
        while (!busy && lat < 12) begin
            @(negedge mclk);
            lat++;
        end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL fresh_ss_entry: got %b expected %b", busy, 1'b1); end
        xfer_word(mo_v, 8, 1'b0, 8'h00, 1'b0, rx);
        ss_end();
        n_checks++;
        if (rx !== tx_v) begin n_errors++; $display("FAIL post_reset_miso: got %h expected %h", rx, tx_v); end
        n_checks++;
        if ({data_out_slave, rx_valid, overrun} !== {mo_v, 2'b10}) begin
            n_errors++;
            $display("FAIL post_reset_rx: got %h expected %h", {data_out_slave, rx_valid, overrun}, {mo_v, 2'b10});
        end
    endtask

    task automatic test_random();
        logic [7:0] rx, exp_tx, tx, lv;
        int nwords;
        bit dl, dr;
        for (int f = 0; f < 15; f++) begin
            if ($urandom_range(1, 0) == 1) load(8'($urandom));
            if ($urandom_range(1, 0) == 1) read_pulse();
            nwords = $urandom_range(3, 1);
            ss_begin();
            for (int w = 0; w < nwords; w++) begin
                exp_tx = m_tx_hold;
                tx = 8'($urandom);
                lv = 8'($urandom);
                dl = ($urandom_range(1, 0) == 1);
                dr = (w > 0) && ($urandom_range(1, 0) == 1);
                xfer_word(tx, 8, dl, lv, dr, rx);
                n_checks++;
                if (rx !== exp_tx) begin n_errors++; $display("FAIL rand_miso f%0d w%0d: got %h expected %h", f, w, rx, exp_tx); end
            end
            ss_end();
            n_checks++;
            if ({data_out_slave, rx_valid, overrun} !== {m_rx_hold, m_rx_valid, m_overrun}) begin
                n_errors++;
                $display("FAIL rand_rx f%0d: got %h expected %h", f, {data_out_slave, rx_valid, overrun}, {m_rx_hold, m_rx_valid, m_overrun});
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_word();
        test_handshake();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_async_reset();
        apply_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
